// File: rtl/color_pkg.sv
// Shared types and constants for the colour read sequencer.
package color_pkg;

    localparam int NUM_COLORS = 4;
    localparam int IDX_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_CAPT = 3'd2,
        ST_SHOW = 3'd3,
        ST_HOLD = 3'd4,
        ST_DONE = 3'd5
    } rd_state_t;

endpackage

// File: rtl/color_read_fsm_hold_counter.sv
// Dwell timer: loads HOLD_CYCLES-1 and counts down to zero.
// Width is kept at least one bit so a HOLD_CYCLES=0 build still elaborates.
module hold_counter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    logic [CNT_W-1:0] count;

    // Load on entry to the dwell, then count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/color_read_fsm.sv
// Read-side sequencer for the 4-entry colour bank: strobes RE1..RE4 in order,
// captures each word, presents it on a valid/ready stream, then dwells.
//
//   state | meaning
//   IDLE  | waiting for go
//   READ  | one-cycle read strobe for colour idx
//   CAPT  | rd_data valid, captured at end of cycle
//   SHOW  | colour presented, waiting for ready
//   HOLD  | dwell after acceptance
//   DONE  | one-cycle completion pulse
module color_read_fsm
    import color_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             loop,
    input  logic             stop,
    output logic             RE1,
    output logic             RE2,
    output logic             RE3,
    output logic             RE4,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] color,
    output logic             color_valid,
    input  logic             color_ready,
    output logic             busy,
    output logic             done
);

    rd_state_t        state;
    rd_state_t        state_nxt;
    rd_state_t        step_target;
    logic [IDX_W-1:0] idx;
    logic             loop_q;
    logic             stop_q;
    logic             accept;
    logic             last;
    logic             rerun;
    logic             step_done;
    logic             hold_zero;

    assign accept      = (state == ST_SHOW) && color_ready;
    assign last        = (idx == IDX_W'(NUM_COLORS - 1));
    assign rerun       = loop_q && !stop_q;
    assign step_target = (last && !rerun) ? ST_DONE : ST_READ;
    assign step_done   = (HOLD_CYCLES == 0) ? accept : ((state == ST_HOLD) && hold_zero);

    hold_counter #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .en   (state == ST_HOLD),
        .zero (hold_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; unreachable encodings fall back to IDLE.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = go ? ST_READ : ST_IDLE;
            ST_READ: state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_SHOW;
            ST_SHOW: begin
                if (accept) begin
                    state_nxt = (HOLD_CYCLES == 0) ? step_target : ST_HOLD;
                end else begin
                    state_nxt = ST_SHOW;
                end
            end
            ST_HOLD: state_nxt = hold_zero ? step_target : ST_HOLD;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Index, captured colour and the loop/stop flags latched at go.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            color  <= '0;
            loop_q <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && go) begin
                idx    <= '0;
                loop_q <= loop;
                stop_q <= 1'b0;
            end else begin
                if (busy && stop) begin
                    stop_q <= 1'b1;
                end
                // idx wraps 3->0 here only when the pass repeats.
                if (step_done && (!last || rerun)) begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (state == ST_CAPT) begin
                color <= rd_data;
            end
        end
    end

    assign RE1         = (state == ST_READ) && (idx == 2'd0);
    assign RE2         = (state == ST_READ) && (idx == 2'd1);
    assign RE3         = (state == ST_READ) && (idx == 2'd2);
    assign RE4         = (state == ST_READ) && (idx == 2'd3);
    assign color_valid = (state == ST_SHOW);
    assign done        = (state == ST_DONE);
    assign busy        = (state == ST_READ) || (state == ST_CAPT) || (state == ST_SHOW) ||
                         (state == ST_HOLD) || (state == ST_DONE);

endmodule
